// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and FSM encoding for the ALU issue controller
package alu_pkg;

  localparam int DW   = 19;
  localparam int NREG = 4;
  localparam int AW   = $clog2(NREG);

  localparam logic [3:0] OP_INCR = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_SUBI = 4'd2;
  localparam logic [3:0] OP_ADDR = 4'd3;
  localparam logic [3:0] OP_SUBR = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Immediate forms take operand B from the command instead of the register file
  function automatic logic is_imm_op(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

  // Only subtractions update the stored zero flag
  function automatic logic is_sub_op(input logic [3:0] op);
    return (op == OP_SUBI) || (op == OP_SUBR);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_OR;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREG x DW register file, two async reads, debug read, one sync write
module alu_regfile
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          RST,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [DW-1:0] o_rdata_a,
  output logic [DW-1:0] o_rdata_b,
  output logic [DW-1:0] o_dbg_data
);

  logic [DW-1:0] r_mem [NREG];

  // Clear every entry on reset, otherwise apply the single write port
  always_ff @(posedge clk) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues register-file commands to an external ALU and returns results
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          RST,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [1:0]    cmd_dst,
  input  logic [1:0]    cmd_srca,
  input  logic [1:0]    cmd_srcb,
  input  logic [DW-1:0] cmd_imm,
  output logic [3:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_z,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_z,
  output logic          res_err,
  input  logic [1:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_t        r_state;
  logic [1:0]    r_dst;
  logic          r_z;
  logic [3:0]    r_alu_op;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic          r_res_valid;
  logic [DW-1:0] r_res_data;
  logic          r_res_z;
  logic          r_res_err;

  logic [DW-1:0] w_rd_a;
  logic [DW-1:0] w_rd_b;
  logic [DW-1:0] w_opnd_b;
  logic          w_we;

  alu_regfile u_regfile (
    .clk        (clk),
    .RST        (RST),
    .i_we       (w_we),
    .i_waddr    (r_dst),
    .i_wdata    (alu_result),
    .i_raddr_a  (cmd_srca),
    .i_raddr_b  (cmd_srcb),
    .i_dbg_addr (dbg_addr),
    .o_rdata_a  (w_rd_a),
    .o_rdata_b  (w_rd_b),
    .o_dbg_data (dbg_data)
  );

  assign w_opnd_b  = is_imm_op(cmd_op) ? cmd_imm : w_rd_b;
  assign w_we      = (r_state == ST_CAPTURE);
  assign cmd_ready = (r_state == ST_IDLE);

  // Command FSM; ALU inputs are loaded at accept so they are live during ISSUE,
  // and forced back to zero outside ISSUE/CAPTURE so each issue is a visible change
  always_ff @(posedge clk) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_dst       <= '0;
      r_z         <= 1'b0;
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_z     <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_dst <= cmd_dst;
            if (is_legal_op(cmd_op)) begin
              r_alu_op <= cmd_op;
              r_alu_a  <= w_rd_a;
              r_alu_b  <= w_opnd_b;
              r_state  <= ST_ISSUE;
            end else begin
              r_res_valid <= 1'b1;
              r_res_err   <= 1'b1;
              r_res_data  <= '0;
              r_res_z     <= r_z;
              r_state     <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_res_valid <= 1'b1;
          r_res_err   <= 1'b0;
          r_res_data  <= alu_result;
          if (is_sub_op(r_alu_op)) begin
            r_z     <= alu_z;
            r_res_z <= alu_z;
          end else begin
            r_res_z <= r_z;
          end
          r_alu_op <= '0;
          r_alu_a  <= '0;
          r_alu_b  <= '0;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alu_op    = r_alu_op;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_z     = r_res_z;
  assign res_err   = r_res_err;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator for the downsampling datapath ALU: accepts commands over a valid/ready handshake and reads operands from an internal 4-entry register file.
- Drives the ALU's opcode/operand inputs and captures the ALU result and registered zero flag.
- Writes the result back to the register file and returns it on a valid/ready response channel.
- Sits between the processor's instruction decode and the ALU.

Parameters:
- DW, 19, datapath width; must match the ALU.
- NREG, 4, register file entries; address width is log2(NREG).

Ports:
- clk  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  4  opcode (0 INCR, 1 ADDI, 2 SUBI, 3 ADDR, 4 SUBR, 5 SHL, 6 SHR, 7 OR; 8-15 illegal)
- cmd_dst  in  2  destination register
- cmd_srca  in  2  operand A register
- cmd_srcb  in  2  operand B register
- cmd_imm  in  DW  immediate; used as B for ADDI/SUBI only
- alu_op  out  4  to ALU opcode
- alu_a  out  DW  to ALU operand A
- alu_b  out  DW  to ALU operand B
- alu_result  in  DW  from ALU result (combinational)
- alu_z  in  1  from ALU zero flag (registered in the ALU)
- res_valid  out  1  response present
- res_ready  in  1  consumer accepts response
- res_data  out  DW  result value
- res_z  out  1  zero status
- res_err  out  1  illegal opcode
- dbg_addr  in  2  register file debug read address
- dbg_data  out  DW  register file content, combinational read

Behaviour:
- Reset (RST=0 at an edge):
  - State IDLE; all registers = 0; stored z = 0.
  - alu_op = 0, alu_a = 0, alu_b = 0.
  - res_valid = 0, res_data = 0, res_z = 0, res_err = 0.
  - cmd_ready = 1 after reset deasserts.
- Reset mid-operation aborts the command: no writeback, no response.
- FSM IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
- IDLE:
  - cmd_ready = 1 and alu_a/alu_b are held at 0, so every issue produces an operand change.
  - On cmd_valid, latch cmd_op/dst/imm and the operands (A = reg[srca]; B = cmd_imm for ops 1-2, else reg[srcb]).
  - A legal opcode goes to ISSUE.
  - An illegal opcode goes directly to RESP with res_err = 1, res_data = 0, res_z = stored z, and no writeback.
- ISSUE (1 cycle): drive alu_op/alu_a/alu_b from the latched values. The ALU registers z at the end of this cycle.
- CAPTURE (1 cycle):
  - Hold the ALU inputs unchanged.
  - Write alu_result to reg[dst] and capture res_data = alu_result.
  - For SUBI/SUBR, set stored z = alu_z and res_z = alu_z. For other ops, res_z = stored z, unchanged.
- RESP:
  - ALU inputs return to 0.
  - res_valid = 1, and res_data/res_z/res_err are stable until res_ready.
  - On res_valid & res_ready, go to IDLE and drop res_valid next cycle.
- cmd_ready is high only in IDLE.
- Latency: accept at edge N, res_valid high in the cycle after edge N+2.
- Minimum command spacing is 4 cycles with res_ready tied high.
- No hazards arise: writeback completes before the next command is accepted. A command may read the register it just wrote.
- Arithmetic is modulo 2^DW and wraps silently, e.g. 0x7FFFF + 1 = 0.
- SHL/SHR use the full B value as the shift amount; B >= DW yields 0.
- dbg_data reflects a write in the cycle after CAPTURE.

Decomposition:
- Package alu_pkg:
  - DW localparam.
  - Opcode constants OP_INCR..OP_OR.
  - FSM state encoding.
  - An is_imm_op(op) function (true for ADDI, SUBI).
- Sub-module alu_regfile:
  - NREG x DW storage.
  - Two combinational read ports plus debug read.
  - One synchronous write port.
  - Synchronous active-low clear.
- A behavioural ALU model belongs in the bench, not in this block.

Test Plan:
- Reset then dbg read r0..r3 -> all 0; cmd_ready = 1, res_valid = 0, alu_op/a/b = 0.
- ADDI r1 = r0 + 5; ADDI r2 = r0 + 5; SUBR r3 = r1 - r2 -> responses 5, 5, 0, with res_z = 1 on SUBR. Then INCR r3 -> res_data = 1, res_z still 1.
- ADDI r1 = r0 + 0x7FFFF; INCR r1 -> res_data = 0 (wrap), res_z unchanged. SHL with r2 = 20 -> 0; SHR 0x40000 by 18 -> 1.
- cmd_op = 9 -> res_err = 1, res_data = 0, no register changes, no ALU activity (alu_op/a/b stay 0).
- Hold res_ready = 0 for 5 cycles -> res_valid/res_data stable and cmd_ready = 0 throughout. Release -> next command accepted the following cycle.
- Assert RST low during CAPTURE of ADDI r1 = r0 + 7 -> r1 = 0, no response, IDLE one cycle after release.
